// File: rtl/ai_frame_monitor.sv
// ai_frame_monitor
//
// Checks one inbound feature frame per init strobe. Three checks run on it:
//   - CRC-8 (poly 0x07, init 0x00, MSB first, no reflection, no output XOR)
//     over every bit of every accepted beat, compared with the CRC that
//     arrives alongside the last beat;
//   - the accepted beat count, compared with EXP_WORDS;
//   - an inter-beat watchdog that gives up after TIMEOUT idle RUN cycles.
// The results are reported as single-cycle registered pulses, which the
// downstream sticky status block latches.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   init_i      start (or restart) of a frame
//   in_valid_i  data beat qualifier
//   in_data_i   data beat, DATA_W bits
//   in_last_i   final beat of the frame, qualified by in_valid_i
//   crc_in_i    transmitted CRC, sampled with the last beat
//   busy_o      high while a frame is open (state is not IDLE)
//   done_o      one-cycle pulse when a frame closes through CHECK
//   crc_err_o   one-cycle pulse on CRC mismatch
//   nde_err_o   one-cycle pulse when the beat count differs from EXP_WORDS
//   tmr_err_o   one-cycle pulse on watchdog expiry
//   word_cnt_o  beats accepted in the current or most recent frame
//
// TIMEOUT must be at least 2.
module ai_frame_monitor #(
  parameter int DATA_W    = 8,
  parameter int EXP_WORDS = 64,
  parameter int TIMEOUT   = 100000,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  input  logic [7:0]        crc_in_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              crc_err_o,
  output logic              nde_err_o,
  output logic              tmr_err_o,
  output logic [CNT_W-1:0]  word_cnt_o
);

  // The watchdog is CNT_W bits wide, but it is made wider whenever TIMEOUT
  // does not fit in CNT_W bits; otherwise the watchdog could never expire.
  localparam int WD_W = (CNT_W > $clog2(TIMEOUT + 1)) ? CNT_W : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] EXP_CNT = CNT_W'(EXP_WORDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       crc_q, crc_d;
  logic [7:0]       crc_rx_q, crc_rx_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             done_q, done_d;
  logic             crc_err_q, crc_err_d;
  logic             nde_err_q, nde_err_d;
  logic             tmr_err_q, tmr_err_d;

  // Shift-register form of CRC-8/0x07. The whole beat is folded in within
  // one cycle, starting with the MSB.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                           input logic [DATA_W-1:0] data);
    logic [7:0] c;
    c = crc;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (c[7] ^ data[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else                c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  always_comb begin
    // NOTE: every signal driven here gets a default first. Then no path
    // leaves a signal unassigned, so no latch is inferred.
    state_d    = state_q;
    crc_d      = crc_q;
    crc_rx_d   = crc_rx_q;
    word_cnt_d = word_cnt_q;
    wdog_d     = wdog_q;
    done_d     = 1'b0;
    crc_err_d  = 1'b0;
    nde_err_d  = 1'b0;
    tmr_err_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A beat in the same cycle as init is ignored. So are all beats
        // outside a frame.
        if (init_i) begin
          state_d    = RUN;
          crc_d      = 8'h00;
          word_cnt_d = '0;
          wdog_d     = '0;
        end
      end

      RUN: begin
        if (init_i) begin
          // Restart: init takes priority over a beat in the same cycle,
          // and that beat is discarded.
          crc_d      = 8'h00;
          word_cnt_d = '0;
          wdog_d     = '0;
        end else if (in_valid_i) begin
          crc_d  = crc8_step(crc_q, in_data_i);
          wdog_d = '0;
          if (word_cnt_q != '1) word_cnt_d = word_cnt_q + CNT_W'(1);
          if (in_last_i) begin
            crc_rx_d = crc_in_i;
            state_d  = CHECK;
          end
        end else if (wdog_q == WD_LAST) begin
          // This idle cycle takes the watchdog to TIMEOUT.
          wdog_d    = wdog_q + WD_W'(1);
          tmr_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end

      CHECK: begin
        done_d    = 1'b1;
        crc_err_d = (crc_q != crc_rx_q);
        nde_err_d = (word_cnt_q != EXP_CNT);
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments. Every register then samples
  // the values from before the edge, however the blocks are ordered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      crc_q      <= 8'h00;
      crc_rx_q   <= 8'h00;
      word_cnt_q <= '0;
      wdog_q     <= '0;
      done_q     <= 1'b0;
      crc_err_q  <= 1'b0;
      nde_err_q  <= 1'b0;
      tmr_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      crc_rx_q   <= crc_rx_d;
      word_cnt_q <= word_cnt_d;
      wdog_q     <= wdog_d;
      done_q     <= done_d;
      crc_err_q  <= crc_err_d;
      nde_err_q  <= nde_err_d;
      tmr_err_q  <= tmr_err_d;
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;
  assign crc_err_o  = crc_err_q;
  assign nde_err_o  = nde_err_q;
  assign tmr_err_o  = tmr_err_q;
  assign word_cnt_o = word_cnt_q;

endmodule

// File: tb/tb_ai_frame_monitor.sv
// Testbench for ai_frame_monitor: directed scenarios followed by randomized
// frames. A frame-level reference model predicts each frame's outcome from
// the beats that are sent.
module tb_ai_frame_monitor;

  localparam int DATA_W    = 8;
  localparam int EXP_WORDS = 9;
  localparam int TIMEOUT   = 16;
  localparam int CNT_W     = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              init_i;
  logic              in_valid_i;
  logic [DATA_W-1:0] in_data_i;
  logic              in_last_i;
  logic [7:0]        crc_in_i;
  logic              busy_o;
  logic              done_o;
  logic              crc_err_o;
  logic              nde_err_o;
  logic              tmr_err_o;
  logic [CNT_W-1:0]  word_cnt_o;

  ai_frame_monitor #(
    .DATA_W   (DATA_W),
    .EXP_WORDS(EXP_WORDS),
    .TIMEOUT  (TIMEOUT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .init_i    (init_i),
    .in_valid_i(in_valid_i),
    .in_data_i (in_data_i),
    .in_last_i (in_last_i),
    .crc_in_i  (crc_in_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .crc_err_o (crc_err_o),
    .nde_err_o (nde_err_o),
    .tmr_err_o (tmr_err_o),
    .word_cnt_o(word_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_tmr    = 0;
  int exp_done = 0;
  int exp_tmr  = 0;

  // Count every pulse, so that spurious pulses outside the checked windows
  // are caught as well.
  always @(negedge clk) begin
    if (done_o)    n_done++;
    if (tmr_err_o) n_tmr++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference CRC, computed as a textbook mod-2 long division: the message
  // bits followed by 8 zero bits, divided by x^8+x^2+x+1.
  function automatic logic [7:0] crc_ref(input logic [7:0] q[$]);
    logic [8:0] rem;
    rem = '0;
    for (int k = 0; k < q.size() * 8 + 8; k++) begin
      logic b;
      b = (k < q.size() * 8) ? q[k / 8][7 - (k % 8)] : 1'b0;
      rem = {rem[7:0], b};
      if (rem[8]) rem = rem ^ 9'h107;
    end
    return rem[7:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last, input logic [7:0] crc);
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_last_i  = last;
    crc_in_i   = crc;
    step();
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic open_frame(input bit junk);
    init_i     = 1'b1;
    in_valid_i = junk;
    in_data_i  = 8'($urandom);
    in_last_i  = junk;
    step();
    init_i     = 1'b0;
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    check("open_busy", busy_o, 1);
    check("open_cnt", word_cnt_o, 0);
  endtask

  // Sends a whole frame (every gap must stay below TIMEOUT), then checks the
  // CHECK cycle and the result pulses against the model.
  task automatic send_frame(input logic [7:0] q[$], input int gap[$], input logic [7:0] crc_tx,
                            input bit do_init, input bit junk_init, input bit junk_check);
    logic exp_crc, exp_nde;
    if (do_init) open_frame(junk_init);
    for (int k = 0; k < q.size(); k++) begin
      repeat (gap[k]) step();
      send_beat(q[k], k == q.size() - 1, (k == q.size() - 1) ? crc_tx : 8'($urandom));
    end
    exp_crc = (crc_tx != crc_ref(q));
    exp_nde = (q.size() != EXP_WORDS);
    check("chk_busy", busy_o, 1);
    check("chk_done_early", done_o, 0);
    // In CHECK, beats and init are ignored.
    init_i     = junk_check;
    in_valid_i = junk_check;
    in_last_i  = junk_check;
    in_data_i  = 8'($urandom);
    step();
    init_i     = 1'b0;
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    exp_done++;
    check("done", done_o, 1);
    check("crc_err", crc_err_o, exp_crc);
    check("nde_err", nde_err_o, exp_nde);
    check("tmr_quiet", tmr_err_o, 0);
    check("busy_fall", busy_o, 0);
    check("word_cnt", word_cnt_o, q.size());
    step();
    check("done_clear", done_o, 0);
    check("crc_err_clear", crc_err_o, 0);
    check("nde_err_clear", nde_err_o, 0);
    check("cnt_hold", word_cnt_o, q.size());
  endtask

  logic [7:0] ascii[$];
  logic [7:0] q[$];
  int         gaps[$];
  int         zeros[$];

  initial begin
    ascii = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    zeros = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    rst = 1'b1; init_i = 0; in_valid_i = 0; in_data_i = 0; in_last_i = 0; crc_in_i = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_cnt", word_cnt_o, 0);
    check("rst_pulses", {done_o, crc_err_o, nde_err_o, tmr_err_o}, 0);
    rst = 1'b0;
    step();

    // Beats outside a frame are ignored.
    send_beat(8'hAA, 1'b1, 8'h00);
    check("idle_ignore_busy", busy_o, 0);
    check("idle_ignore_cnt", word_cnt_o, 0);

    // Clean frame, CRC fault, length fault.
    send_frame(ascii, zeros, 8'hF4, 1, 0, 0);
    send_frame(ascii, zeros, 8'hF5, 1, 0, 0);
    q = '{8'h01};
    gaps = '{0};
    send_frame(q, gaps, 8'h07, 1, 0, 0);

    // Watchdog: 3 beats, then silence.
    open_frame(0);
    for (int k = 0; k < 3; k++) send_beat(8'($urandom), 1'b0, 8'h00);
    for (int k = 1; k < TIMEOUT; k++) begin
      step();
      check("wd_quiet", tmr_err_o, 0);
      check("wd_busy", busy_o, 1);
    end
    step();
    exp_tmr++;
    check("wd_tmr", tmr_err_o, 1);
    check("wd_busy_fall", busy_o, 0);
    check("wd_no_done", {done_o, crc_err_o, nde_err_o}, 0);
    step();
    check("wd_tmr_clear", tmr_err_o, 0);
    check("wd_cnt_hold", word_cnt_o, 3);

    // Restart mid-frame with a simultaneous beat.
    open_frame(1);
    for (int k = 0; k < 4; k++) send_beat(8'($urandom), 1'b0, 8'h00);
    init_i = 1'b1;
    send_beat(8'h55, 1'b0, 8'h00);
    init_i = 1'b0;
    check("rs_cnt", word_cnt_o, 0);
    check("rs_busy", busy_o, 1);
    check("rs_pulses", {done_o, crc_err_o, nde_err_o, tmr_err_o}, 0);
    send_frame(ascii, zeros, 8'hF4, 0, 0, 0);

    // Asynchronous reset between clock edges, mid-frame.
    open_frame(0);
    for (int k = 0; k < 5; k++) send_beat(8'($urandom), 1'b0, 8'h00);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("ar_busy", busy_o, 0);
    check("ar_cnt", word_cnt_o, 0);
    check("ar_pulses", {done_o, crc_err_o, nde_err_o, tmr_err_o}, 0);
    #2 rst = 1'b0;
    step();
    send_frame(ascii, zeros, 8'hF4, 1, 0, 0);

    // Randomized frames, with gaps of up to TIMEOUT-1 idle cycles.
    for (int f = 0; f < 30; f++) begin
      int len;
      logic [7:0] crc_tx;
      len = $urandom_range(12, 1);
      q.delete();
      gaps.delete();
      for (int k = 0; k < len; k++) begin
        int r;
        q.push_back(8'($urandom));
        r = $urandom_range(9, 0);
        gaps.push_back(r < 6 ? 0 : (r < 9 ? $urandom_range(3, 1) : TIMEOUT - 1));
      end
      crc_tx = crc_ref(q);
      if ($urandom_range(1, 0) == 1) crc_tx = crc_tx ^ 8'(1 << $urandom_range(7, 0));
      send_frame(q, gaps, crc_tx, 1, 1'($urandom), 1'($urandom));
      repeat ($urandom_range(2, 0)) begin
        send_beat(8'($urandom), 1'($urandom), 8'($urandom));
        check("idle_cnt_hold", word_cnt_o, len);
      end
    end

    step();
    check("done_pulse_count", n_done, exp_done);
    check("tmr_pulse_count", n_tmr, exp_tmr);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
